// File: rtl/decode_stage.sv
// ID stage: regfile read with WB bypass, immediate generation, load-use stall, ID/EX register.
// One cycle ID to ID/EX; the in-flight word is held locally while fetch is stalled.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ifid_pc,
  input  logic [31:0] imem_dout,
  input  logic        id_flush,
  input  logic        ext_stall,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  output logic        if_stall,
  output logic        idex_valid,
  output logic [31:0] idex_pc,
  output logic [31:0] idex_inst,
  output logic [31:0] idex_rs1_data,
  output logic [31:0] idex_rs2_data,
  output logic [31:0] idex_imm
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        valid_q;
  logic [31:0] pc_q, inst_q, rs1_q, rs2_q, imm_q;
  logic        hold_valid_q;
  logic [31:0] hold_inst_q;

  logic [31:0] cur_inst;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, ex_rd;
  logic        rs1_used, rs2_used, hazard;
  logic [31:0] rs1_d, rs2_d, imm_d;

  assign cur_inst    = hold_valid_q ? hold_inst_q : imem_dout;
  assign opcode      = cur_inst[6:0];
  assign rs1         = cur_inst[19:15];
  assign rs2         = cur_inst[24:20];
  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign ex_rd  = inst_q[11:7];
  assign hazard = valid_q && (inst_q[6:0] == OP_LOAD) && (ex_rd != 5'd0) &&
                  ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));

  assign if_stall = (hazard || ext_stall) && !id_flush;

  // Same-cycle writeback wins over the stale regfile value; x0 is forced to zero.
  always_comb begin
    rs1_d = rf_rs1_data;
    rs2_d = rf_rs2_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs1) rs1_d = wb_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs2) rs2_d = wb_data;
    if (rs1 == 5'd0) rs1_d = 32'd0;
    if (rs2 == 5'd0) rs2_d = 32'd0;
  end

  always_comb begin
    imm_d = 32'd0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm_d = {{20{cur_inst[31]}}, cur_inst[31:20]};
      OP_STORE:
        imm_d = {{20{cur_inst[31]}}, cur_inst[31:25], cur_inst[11:7]};
      OP_BRANCH:
        imm_d = {{19{cur_inst[31]}}, cur_inst[31], cur_inst[7], cur_inst[30:25],
                 cur_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_d = {cur_inst[31:12], 12'd0};
      OP_JAL:
        imm_d = {{11{cur_inst[31]}}, cur_inst[31], cur_inst[19:12], cur_inst[20],
                 cur_inst[30:21], 1'b0};
      default:
        imm_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      rs1_q        <= 32'd0;
      rs2_q        <= 32'd0;
      imm_q        <= 32'd0;
      hold_valid_q <= 1'b0;
      hold_inst_q  <= 32'd0;
    end else if (id_flush) begin
      valid_q      <= 1'b0;
      pc_q         <= ifid_pc;
      inst_q       <= NOP_INST;
      rs1_q        <= 32'd0;
      rs2_q        <= 32'd0;
      imm_q        <= 32'd0;
      hold_valid_q <= 1'b0;
    end else if (ext_stall || hazard) begin
      // ext_stall freezes ID/EX entirely; a bare hazard injects a bubble.
      if (!ext_stall) begin
        valid_q <= 1'b0;
        pc_q    <= ifid_pc;
        inst_q  <= NOP_INST;
        rs1_q   <= 32'd0;
        rs2_q   <= 32'd0;
        imm_q   <= 32'd0;
      end
      if (!hold_valid_q) begin
        hold_inst_q  <= imem_dout;
        hold_valid_q <= 1'b1;
      end
    end else begin
      valid_q      <= 1'b1;
      pc_q         <= ifid_pc;
      inst_q       <= cur_inst;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      imm_q        <= imm_d;
      hold_valid_q <= 1'b0;
    end
  end

  assign idex_valid    = valid_q;
  assign idex_pc       = pc_q;
  assign idex_inst     = inst_q;
  assign idex_rs1_data = rs1_q;
  assign idex_rs2_data = rs2_q;
  assign idex_imm      = imm_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 3/5-stage RV32I core. It sits directly downstream of the fetch stage and consumes its IF/ID PC together with the synchronous IMEM/BIOS read data.
- Reads the register file, bypasses same-cycle writeback, generates the immediate, detects load-use hazards (stall back to fetch), and registers the ID/EX pipeline word.
- Holds the in-flight instruction across stalls. Fetch re-addresses IMEM while stalled, so raw IMEM data is not stable.

Parameters:
- RESET_PC, 32'h4000_0000: reset value of idex_pc.
- NOP_INST, 32'h0000_0000: instruction word inserted for bubbles and flushes.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- ifid_pc  in  32  PC of instruction in ID
- imem_dout  in  32  synchronous IMEM read data, aligned with ifid_pc
- id_flush  in  1  kill instruction in ID (branch/jump redirect)
- ext_stall  in  1  downstream freeze (memory busy)
- rf_rs1_data  in  32  combinational regfile read port 1
- rf_rs2_data  in  32  combinational regfile read port 2
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback value
- rf_rs1_addr  out  5  inst[19:15] of current instruction
- rf_rs2_addr  out  5  inst[24:20] of current instruction
- if_stall  out  1  hold fetch and IF/ID (combinational)
- idex_valid  out  1  ID/EX holds a real instruction
- idex_pc  out  32  registered PC
- idex_inst  out  32  registered instruction
- idex_rs1_data  out  32  registered rs1 operand
- idex_rs2_data  out  32  registered rs2 operand
- idex_imm  out  32  registered sign-extended immediate

Behaviour:
- **Reset:** reset_n low asynchronously sets idex_valid=0, idex_pc=RESET_PC, idex_inst=NOP_INST, idex_rs1_data/rs2_data/imm=0, hold_valid=0, hold_inst=0.
- **Current instruction:** cur_inst = hold_valid ? hold_inst : imem_dout.
- **Register addresses:** rf_rs1_addr and rf_rs2_addr are always decoded from cur_inst.
- **Source usage:**
  - rs1 is used unless opcode is LUI(0110111), AUIPC(0010111) or JAL(1101111).
  - rs2 is used only for opcodes 0110011, 0100011 and 1100011.
- **Hazard:** hazard = idex_valid & idex opcode==0000011 & idex rd!=0 & ((rs1 used & idex rd==rs1) | (rs2 used & idex rd==rs2)).
- **Stall output:** if_stall = (hazard | ext_stall) & ~id_flush.
- **WB bypass:** operand = wb_data when wb_we & wb_rd!=0 & wb_rd==rsN; otherwise the regfile data. x0 always reads 0.
- **Immediate:** sign-extended from inst[31] per format.
  - I: loads, OP-IMM, JALR, SYSTEM.
  - S, B, U and J formats as in the ISA.
  - R-type: 0.
  - B and J immediates have bit0=0.
- **Per-edge priority (highest first):**
  1. id_flush: ID/EX <= bubble (valid=0, inst=NOP_INST, pc=ifid_pc), hold_valid <= 0.
  2. ext_stall: all ID/EX regs hold. If !hold_valid, then hold_inst <= imem_dout and hold_valid <= 1.
  3. hazard: ID/EX <= bubble. Same hold capture as step 2.
  4. Otherwise: ID/EX <= {1, ifid_pc, cur_inst, operands, imm}, hold_valid <= 0.
- **Hold register:**
  - Captures exactly once per stall episode; back-to-back stall cycles keep the first captured word.
  - Release occurs in the first non-stalled, non-flushed cycle. The held word is consumed on that edge.
- **Latency:** 1 cycle from ID to ID/EX. A load-use hazard costs exactly one bubble.
- **Flush during a stall** discards the held word. The next instruction comes from imem_dout.
- **Reset mid-stall** discards the held word. if_stall is 0 once reset is released with idex_valid=0.
- **Bubble content:** bubbles carry rd=x0, so they never trigger a hazard or a writeback.

Test Plan:
- **Reset:** reset_n low mid-cycle -> outputs clear immediately. idex_pc=0x4000_0000, idex_valid=0, if_stall=0.
- **Straight-line issue:** issue ADDI x5,x0,-1 (0xFFF00293) at pc 0x4000_0000 -> next edge idex_valid=1, idex_imm=0xFFFF_FFFF, idex_pc=0x4000_0000, rf_rs1_addr=0.
- **Load-use:** LW x6,0(x1) followed by ADD x7,x6,x2 -> if_stall=1 for one cycle and one bubble.
  - ADD issues from hold_inst even though imem_dout changes to the next word during the stall.
- **WB bypass:** wb_we=1, wb_rd=3, wb_data=0xDEAD_BEEF with rf_rs1_data=0 for SUB x4,x3,x3 -> idex_rs1_data=idex_rs2_data=0xDEAD_BEEF.
- **x0 write:** wb_rd=0, wb_data=5 -> no bypass, operand=0.
- **Flush during stall:** id_flush asserted during a load-use stall -> bubble, hold_valid=0, if_stall=0 that cycle. Next issued instruction equals the new imem_dout.
- **Immediates:** ext_stall for 3 cycles with a held BEQ (imm=-8) -> ID/EX frozen 3 cycles, then idex_imm=0xFFFF_FFF8 issued once. JAL imm=+2048 -> idex_imm=0x0000_0800.
